// File: rtl/hazard_pkg.sv
// Shared opcodes, bubble encoding and FSM state type for the hazard controller.
package hazard_pkg;

    localparam logic [4:0] OP_BNE    = 5'b10011;
    localparam logic [4:0] OP_BE     = 5'b10100;
    localparam logic [4:0] OP_BNER   = 5'b10101;
    localparam logic [4:0] OP_BER    = 5'b10110;
    localparam logic [4:0] OP_J      = 5'b10111;
    localparam logic [4:0] OP_JR     = 5'b11000;
    localparam logic [4:0] OP_LI     = 5'b11001;
    localparam logic [4:0] OP_LOAD   = 5'b11010;
    localparam logic [4:0] OP_STORE  = 5'b11011;
    localparam logic [4:0] BUBBLE_OP = 5'h1f;

    // 2'd3 is unused; the FSM steers it back to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Register-compare branches resolved in ID (ber/bner).
    function automatic logic is_reg_branch(input logic [4:0] op);
        return (op == OP_BER) || (op == OP_BNER);
    endfunction

endpackage

// File: rtl/hazard_control_sat_counter.sv
// Saturating up-counter: counts INC pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Increment on request unless already at the ceiling.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (i_rst)
            r_q <= '0;
        else if (i_inc && (r_q != {W{1'b1}}))
            r_q <= r_q + W'(1);
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_control.sv
// Pipeline interlock/flush controller: load-to-ID-branch bubble, ID and MEM
// redirects, plus saturating cost counters.
module hazard_control
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_ifid_opcode,
    input  logic [2:0]       i_ifid_rd_addr,
    input  logic [2:0]       i_ifid_r2_addr,
    input  logic [4:0]       i_idex_opcode,
    input  logic [2:0]       i_idex_rd_addr,
    input  logic             i_id_branch_taken,
    input  logic             i_mem_branch_taken,
    output logic             o_pc_we,
    output logic             o_ifid_we,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_stall_active,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    state_t r_state;
    state_t w_next;
    logic   w_lu_haz;
    logic   w_inc_stall;
    logic   w_inc_flush;

    // A load in EX feeding an ID-resolved compare/jump cannot be forwarded in time.
    assign w_lu_haz = (i_idex_opcode == OP_LOAD) &&
                      ((is_reg_branch(i_ifid_opcode) &&
                        ((i_ifid_rd_addr == i_idex_rd_addr) ||
                         (i_ifid_r2_addr == i_idex_rd_addr))) ||
                       ((i_ifid_opcode == OP_JR) &&
                        (i_ifid_r2_addr == i_idex_rd_addr)));

    // State register; reset forces RUN asynchronously from any state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_RUN;
        else
            r_state <= w_next;
    end

    // Next-state and control decode: MEM redirect > load-use stall > ID redirect.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_next        = ST_RUN;
        o_pc_we       = 1'b1;
        o_ifid_we     = 1'b1;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        w_inc_stall   = 1'b0;
        w_inc_flush   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_mem_branch_taken) begin
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                    w_next        = ST_FLUSH;
                    w_inc_flush   = 1'b1;
                end else if (w_lu_haz) begin
                    // The ID redirect is ignored: its operand is still stale.
                    o_pc_we      = 1'b0;
                    o_ifid_we    = 1'b0;
                    o_idex_flush = 1'b1;
                    w_next       = ST_STALL;
                    w_inc_stall  = 1'b1;
                end else if (i_id_branch_taken) begin
                    o_ifid_flush = 1'b1;
                    w_inc_flush  = 1'b1;
                end
            end
            ST_STALL: begin
                // Load now sits in EX/MEM where forwarding covers it.
                if (i_mem_branch_taken) begin
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                    w_next        = ST_FLUSH;
                    w_inc_flush   = 1'b1;
                end else if (i_id_branch_taken) begin
                    o_ifid_flush = 1'b1;
                    w_inc_flush  = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Affected stages hold bubbles, so every request is masked.
                w_next = ST_RUN;
            end
            default: begin
                w_next = ST_RUN;
            end
        endcase

        // Hold the pipeline frozen and bubbled while reset is asserted.
        if (i_rst) begin
            o_pc_we       = 1'b0;
            o_ifid_we     = 1'b0;
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            w_inc_stall   = 1'b0;
            w_inc_flush   = 1'b0;
        end
    end

    assign o_stall_active = (r_state == ST_STALL);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_inc_stall),
        .o_q   (o_stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_inc_flush),
        .o_q   (o_flush_count)
    );

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline interlock and flush controller for the 5-stage core. It produces the stall and flush signals that the forwarding network cannot cover on its own. It inserts the one-cycle load-to-ID-branch bubble, redirects on ID-resolved branches (ber/bner/jr/j) and on MEM-resolved branches (be/bne), and counts the cycles it costs. It sits beside the forwarding unit and drives the PC and pipeline-register write/flush controls.

## Interface
- CNT_W, 16, width of saturating performance counters
- CLK  in  1  core clock, rising edge
- RST  in  1  asynchronous, active-high reset
- IFID_OPCODE  in  5  opcode in IF/ID
- IFID_RD_ADDR  in  3  IF/ID RD field (compare operand of ber/bner)
- IFID_R2_ADDR  in  3  IF/ID R2 field (ber/bner/jr operand)
- IDEX_OPCODE  in  5  opcode in ID/EX
- IDEX_RD_ADDR  in  3  ID/EX destination
- ID_BRANCH_TAKEN  in  1  ID-stage redirect (j, or ber/bner/jr resolved taken)
- MEM_BRANCH_TAKEN  in  1  MEM-stage be/bne resolved taken
- PC_WE  out  1  PC update enable
- IFID_WE  out  1  IF/ID load enable
- IFID_FLUSH  out  1  load bubble (opcode 5'h1f) into IF/ID
- IDEX_FLUSH  out  1  load bubble into ID/EX
- EXMEM_FLUSH  out  1  load bubble into EX/MEM
- STALL_ACTIVE  out  1  high while in STALL state
- STALL_COUNT  out  CNT_W  cycles spent in load-use stall
- FLUSH_COUNT  out  CNT_W  redirect events

## Operation
- Opcodes: bne 10011, be 10100, bner 10101, ber 10110, j 10111, jr 11000, li 11001, load 11010, store 11011, bubble 11111.
- LU_HAZ = IDEX_OPCODE==load and either of:
  - IFID_OPCODE in {ber,bner} and (IFID_RD_ADDR==IDEX_RD_ADDR or IFID_R2_ADDR==IDEX_RD_ADDR)
  - IFID_OPCODE==jr and IFID_R2_ADDR==IDEX_RD_ADDR
- Default outputs: PC_WE=1, IFID_WE=1, all FLUSH=0.
- FSM states are RUN, STALL and FLUSH. Reset state is RUN.
- RUN, in priority order:
  1. MEM_BRANCH_TAKEN: IFID_FLUSH=IDEX_FLUSH=EXMEM_FLUSH=1, PC_WE=1. Next state FLUSH. FLUSH_COUNT+1.
  2. LU_HAZ: PC_WE=0, IFID_WE=0, IDEX_FLUSH=1. ID_BRANCH_TAKEN is ignored because its operand is stale. Next state STALL. STALL_COUNT+1.
  3. ID_BRANCH_TAKEN: IFID_FLUSH=1, PC_WE=1. Stay in RUN. FLUSH_COUNT+1.
  4. Otherwise: defaults, stay in RUN.
- STALL:
  - LU_HAZ is masked, because the load is now in EX/MEM and forwarding covers it.
  - MEM_BRANCH_TAKEN is handled as in RUN (goes to FLUSH).
  - Otherwise ID_BRANCH_TAKEN is handled as in RUN, then the FSM returns to RUN.
  - A stall therefore never exceeds one cycle.
- FLUSH:
  - ID_BRANCH_TAKEN, MEM_BRANCH_TAKEN and LU_HAZ are all masked, since the affected stages hold bubbles.
  - Outputs take their defaults. Next state RUN.
- Counters saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from the registered state and the current inputs, with zero-cycle latency.
- State and counters update on the rising edge of CLK.
- While RST is high:
  - PC_WE=0, IFID_WE=0, IFID_FLUSH=IDEX_FLUSH=EXMEM_FLUSH=1.
  - STALL_ACTIVE=0 and both counters are 0.
  - The state returns to RUN asynchronously, including mid-STALL or mid-FLUSH.
- First edge after RST falls: normal RUN decode.
- Simultaneous events resolve as MEM redirect > load-use stall > ID redirect.
- STALL_ACTIVE is registered: high exactly for the cycle after an LU_HAZ detection.

## Structure
- Package hazard_pkg holds:
  - opcode localparams
  - BUBBLE_OP=5'h1f
  - the state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2; 2'd3 is illegal and recovers to RUN)
- Sub-module sat_counter (parameter W; inputs CLK, RST, INC; output Q), instantiated twice.

## Test plan
- Load-use into ber: IDEX=load RD=3, IFID=ber RD=3 → one cycle with PC_WE=0, IFID_WE=0, IDEX_FLUSH=1; next cycle STALL_ACTIVE=1 and outputs at defaults; STALL_COUNT=1.
- Non-hazards: IDEX=load RD=3 with IFID=jr R2=4, or with IFID=add reading 3 → no stall, STALL_COUNT stays 0.
- MEM be taken with LU_HAZ and ID_BRANCH_TAKEN also high → all three FLUSH=1, PC_WE=1; next cycle all inputs masked; FLUSH_COUNT=1, STALL_COUNT=0.
- Back-to-back stall check: hold LU_HAZ inputs constant for 3 cycles → stall, then STALL (masked), then stall again; never two consecutive PC_WE=0 cycles.
- Reset mid-STALL: assert RST asynchronously → immediate PC_WE=0, flushes=1, counters 0; after release the state is RUN.
- Saturation: with CNT_W=4, force 20 stalls → STALL_COUNT holds at 4'hF.
